// File: rtl/p_cacheline_adaptor_pkg.sv
// Shared types for the cache line / memory burst adaptor.
// Line and beat geometry plus the adaptor FSM encoding.
package p_cacheline_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int CNT_W   = $clog2(BEATS);

    typedef logic [LINE_W-1:0]  line_t;
    typedef logic [BURST_W-1:0] beat_t;
    typedef logic [CNT_W-1:0]   beat_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP,
        ST_COOL
    } adaptor_state_t;

    function automatic beat_t line_beat(
        input line_t     l,
        input beat_idx_t idx
    );
        return l[BURST_W*idx +: BURST_W];
    endfunction

endpackage

// File: rtl/p_cacheline_adaptor.sv
// Converts 256-bit cache line requests into 4-beat 64-bit bursts.
// Outputs are decoded from registered state only.
module p_cacheline_adaptor
    import p_cacheline_adaptor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  line_t       pmem_wdata,
    output line_t       pmem_rdata,
    output logic        pmem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output beat_t       mem_wdata,
    input  beat_t       mem_rdata,
    input  logic        mem_resp
);

    adaptor_state_t state_q, state_d;
    beat_idx_t      cnt_q, cnt_d;
    line_t          buf_q, buf_d;
    logic [26:0]    addr_q, addr_d;

    logic           last_beat;
    logic           unused_addr_bits;

    assign last_beat        = (cnt_q == beat_idx_t'(BEATS - 1));
    assign unused_addr_bits = ^pmem_address[4:0];

    // State, beat counter, line buffer and line address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state: accept a request, run the burst, pulse resp, cool down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pmem_write) begin
                    state_d = ST_WRITE;
                    addr_d  = pmem_address[31:5];
                    buf_d   = pmem_wdata;
                end else if (pmem_read) begin
                    state_d = ST_READ;
                    addr_d  = pmem_address[31:5];
                end
            end
            ST_READ: begin
                if (mem_resp) begin
                    buf_d[BURST_W*cnt_q +: BURST_W] = mem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_COOL;
            end
            ST_COOL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_read    = (state_q == ST_READ);
    assign mem_write   = (state_q == ST_WRITE);
    assign pmem_resp   = (state_q == ST_RESP);
    assign mem_address = {addr_q, 5'b0};
    assign mem_wdata   = line_beat(buf_q, cnt_q);
    assign pmem_rdata  = buf_q;

endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Directed bench for the cache line / burst adaptor.
// Each task drives one scenario and checks its own outputs.
module tb_p_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         mem_resp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    p_cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] b2, input logic [63:0] b3);
        mem_resp = 1'b1;
        mem_rdata = b0; tick;
        mem_rdata = b1; tick;
        mem_rdata = b2; tick;
        mem_rdata = b3; tick;
        mem_resp = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        mem_rdata = '0;
        mem_resp = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b expected 000",
                     {mem_read, mem_write, pmem_resp});
        end
        n_cmp++;
        if (mem_address !== 32'h0 || mem_wdata !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mem: got addr %h wdata %h expected 0",
                     mem_address, mem_wdata);
        end
        n_cmp++;
        if (pmem_rdata !== 256'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected 0", pmem_rdata);
        end
        tick;
        n_cmp++;
        if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_quiet: got %b expected 000",
                     {mem_read, mem_write, pmem_resp});
        end
    endtask

    task automatic test_read_consecutive;
        logic [63:0] rb [4];
        rb[0] = 64'h1111_1111_1111_1111;
        rb[1] = 64'h2222_2222_2222_2222;
        rb[2] = 64'h3333_3333_3333_3333;
        rb[3] = 64'h4444_4444_4444_4444;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_1234;
        #1;
        n_cmp++;
        if (mem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_no_comb: got %b expected 0", mem_read);
        end
        tick;
        n_cmp++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_req: got rd %b wr %b expected 1 0",
                     mem_read, mem_write);
        end
        n_cmp++;
        if (mem_address !== 32'h0000_1220) begin
            n_bad++;
            $display("FAIL rd_addr: got %h expected 00001220", mem_address);
        end
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1;
            mem_rdata = rb[i];
            n_cmp++;
            if ({mem_read, pmem_resp} !== 2'b10) begin
                n_bad++;
                $display("FAIL rd_beat%0d: got rd/resp %b expected 10",
                         i, {mem_read, pmem_resp});
            end
            tick;
        end
        mem_resp = 1'b0;
        mem_rdata = '0;
        pmem_read = 1'b0;
        n_cmp++;
        if (pmem_resp !== 1'b1 || mem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_resp: got resp %b rd %b expected 1 0",
                     pmem_resp, mem_read);
        end
        n_cmp++;
        if (pmem_rdata !== {rb[3], rb[2], rb[1], rb[0]}) begin
            n_bad++;
            $display("FAIL rd_data: got %h expected %h", pmem_rdata,
                     {rb[3], rb[2], rb[1], rb[0]});
        end
        tick;
        n_cmp++;
        if (pmem_resp !== 1'b0 || pmem_rdata !== {rb[3], rb[2], rb[1], rb[0]}) begin
            n_bad++;
            $display("FAIL rd_resp_once: got resp %b data %h expected 0 held",
                     pmem_resp, pmem_rdata);
        end
        tick;
    endtask

    task automatic test_write_gapped;
        logic [63:0] wb [4];
        int k;
        bit hit;
        wb[0] = 64'hAAAA_0000_AAAA_0001;
        wb[1] = 64'hBBBB_0000_BBBB_0002;
        wb[2] = 64'hCCCC_0000_CCCC_0003;
        wb[3] = 64'hDDDD_0000_DDDD_0004;
        pmem_write = 1'b1;
        pmem_address = 32'h8000_0040;
        pmem_wdata = {wb[3], wb[2], wb[1], wb[0]};
        tick;
        k = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (cyc == 3) begin
                pmem_write = 1'b0;
            end
            n_cmp++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || pmem_resp !== 1'b0 ||
                mem_wdata !== wb[k] || mem_address !== 32'h8000_0040) begin
                n_bad++;
                $display("FAIL wr_cyc%0d: got wr %b rd %b resp %b addr %h data %h expected 1 0 0 80000040 %h",
                         cyc, mem_write, mem_read, pmem_resp, mem_address,
                         mem_wdata, wb[k]);
            end
            hit = (cyc == 2 || cyc == 5 || cyc == 6 || cyc == 9);
            mem_resp = hit;
            tick;
            mem_resp = 1'b0;
            if (hit) begin
                k++;
            end
        end
        n_cmp++;
        if (pmem_resp !== 1'b1 || mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_resp: got resp %b wr %b expected 1 0",
                     pmem_resp, mem_write);
        end
        tick;
        n_cmp++;
        if (pmem_resp !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_resp_once: got %b expected 0", pmem_resp);
        end
        tick;
    endtask

    task automatic test_held_after_resp;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_0100;
        tick;
        feed(64'h5, 64'h6, 64'h7, 64'h8);
        n_cmp++;
        if (pmem_resp !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_resp: got %b expected 1", pmem_resp);
        end
        tick;
        n_cmp++;
        if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin
            n_bad++;
            $display("FAIL hold_cool: got %b expected 000",
                     {mem_read, mem_write, pmem_resp});
        end
        tick;
        n_cmp++;
        if (mem_read !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_idle: got %b expected 0", mem_read);
        end
        tick;
        n_cmp++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_0100) begin
            n_bad++;
            $display("FAIL hold_restart: got rd %b addr %h expected 1 00000100",
                     mem_read, mem_address);
        end
        pmem_read = 1'b0;
        feed(64'h9, 64'hA, 64'hB, 64'hC);
        n_cmp++;
        if (pmem_resp !== 1'b1 ||
            pmem_rdata !== {64'hC, 64'hB, 64'hA, 64'h9}) begin
            n_bad++;
            $display("FAIL hold_second: got resp %b data %h expected 1 %h",
                     pmem_resp, pmem_rdata, {64'hC, 64'hB, 64'hA, 64'h9});
        end
        tick;
        tick;
    endtask

    task automatic test_simultaneous;
        logic [63:0] sb [4];
        sb[0] = 64'h0123_4567_89AB_CDEF;
        sb[1] = 64'hFEDC_BA98_7654_3210;
        sb[2] = 64'h0F0F_0F0F_F0F0_F0F0;
        sb[3] = 64'h5A5A_A5A5_5A5A_A5A5;
        pmem_read = 1'b1;
        pmem_write = 1'b1;
        pmem_address = 32'h0000_0FE7;
        pmem_wdata = {sb[3], sb[2], sb[1], sb[0]};
        tick;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== sb[i] ||
                mem_address !== 32'h0000_0FE0) begin
                n_bad++;
                $display("FAIL both_beat%0d: got wr %b rd %b addr %h data %h expected 1 0 00000fe0 %h",
                         i, mem_write, mem_read, mem_address, mem_wdata, sb[i]);
            end
            mem_resp = 1'b1;
            tick;
        end
        mem_resp = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        n_cmp++;
        if (pmem_resp !== 1'b1 || mem_read !== 1'b0 ||
            pmem_rdata !== {sb[3], sb[2], sb[1], sb[0]}) begin
            n_bad++;
            $display("FAIL both_resp: got resp %b rd %b data %h expected 1 0 %h",
                     pmem_resp, mem_read, pmem_rdata, {sb[3], sb[2], sb[1], sb[0]});
        end
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        bit saw;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_2000;
        tick;
        mem_resp = 1'b1;
        mem_rdata = 64'h7777_7777_7777_7777;
        tick;
        mem_rdata = 64'h8888_8888_8888_8888;
        tick;
        mem_resp = 1'b0;
        mem_rdata = '0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        pmem_read = 1'b0;
        n_cmp++;
        if ({mem_read, mem_write, pmem_resp} !== 3'b000 ||
            mem_address !== 32'h0 || mem_wdata !== 64'h0 ||
            pmem_rdata !== 256'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got ctl %b addr %h wdata %h rdata %h expected all 0",
                     {mem_read, mem_write, pmem_resp}, mem_address, mem_wdata,
                     pmem_rdata);
        end
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (pmem_resp !== 1'b0 || mem_read !== 1'b0) begin
                saw = 1'b1;
            end
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_resp: got activity %b expected 0", saw);
        end
        pmem_read = 1'b1;
        pmem_address = 32'h0000_3010;
        tick;
        n_cmp++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_3000) begin
            n_bad++;
            $display("FAIL rst_after_req: got rd %b addr %h expected 1 00003000",
                     mem_read, mem_address);
        end
        pmem_read = 1'b0;
        feed(64'h9999, 64'hAAAA, 64'hBBBB, 64'hCCCC);
        n_cmp++;
        if (pmem_resp !== 1'b1 ||
            pmem_rdata !== {64'hCCCC, 64'hBBBB, 64'hAAAA, 64'h9999}) begin
            n_bad++;
            $display("FAIL rst_after_data: got resp %b data %h expected 1 %h",
                     pmem_resp, pmem_rdata,
                     {64'hCCCC, 64'hBBBB, 64'hAAAA, 64'h9999});
        end
        tick;
        tick;
    endtask

    task automatic test_stray_resp;
        logic [255:0] held;
        logic [255:0] fresh;
        held = {64'hCCCC, 64'hBBBB, 64'hAAAA, 64'h9999};
        fresh = {64'hF4, 64'hF3, 64'hF2, 64'hF1};
        mem_resp = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick;
        tick;
        tick;
        mem_resp = 1'b0;
        n_cmp++;
        if ({mem_read, mem_write, pmem_resp} !== 3'b000 || pmem_rdata !== held) begin
            n_bad++;
            $display("FAIL stray_idle: got ctl %b data %h expected 000 %h",
                     {mem_read, mem_write, pmem_resp}, pmem_rdata, held);
        end
        pmem_read = 1'b1;
        pmem_address = 32'h0000_4000;
        tick;
        pmem_read = 1'b0;
        feed(64'hF1, 64'hF2, 64'hF3, 64'hF4);
        n_cmp++;
        if (pmem_resp !== 1'b1 || pmem_rdata !== fresh) begin
            n_bad++;
            $display("FAIL stray_cnt: got resp %b data %h expected 1 %h",
                     pmem_resp, pmem_rdata, fresh);
        end
        mem_resp = 1'b1;
        mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        tick;
        tick;
        mem_resp = 1'b0;
        mem_rdata = '0;
        n_cmp++;
        if ({mem_read, mem_write, pmem_resp} !== 3'b000 || pmem_rdata !== fresh) begin
            n_bad++;
            $display("FAIL stray_cool: got ctl %b data %h expected 000 %h",
                     {mem_read, mem_write, pmem_resp}, pmem_rdata, fresh);
        end
        pmem_read = 1'b1;
        pmem_address = 32'h0000_5000;
        tick;
        pmem_read = 1'b0;
        feed(64'hE1, 64'hE2, 64'hE3, 64'hE4);
        n_cmp++;
        if (pmem_resp !== 1'b1 ||
            pmem_rdata !== {64'hE4, 64'hE3, 64'hE2, 64'hE1}) begin
            n_bad++;
            $display("FAIL stray_after: got resp %b data %h expected 1 %h",
                     pmem_resp, pmem_rdata, {64'hE4, 64'hE3, 64'hE2, 64'hE1});
        end
        tick;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_consecutive();
        test_write_gapped();
        test_held_after_resp();
        test_simultaneous();
        test_reset_mid();
        test_stray_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
